axi_frame_arbiter: RTL and testbench
====================================

Name: axi_frame_arbiter

Overview:
- Frame-granular round-robin multiplexer merging NUM_PORTS AXI-Stream sources into one AXI-Stream sink; all ports share a single clock.
- Typical use: per-source axi_async_fifo outputs feed this block, which feeds the shared MAC TX path.
- Grant is held from the first beat of a frame through its tlast beat, so frames never interleave.
- Output is fully registered; m_axis_tuser (bad-frame flag) passes through so a downstream FIFO can drop the frame.

Parameters:
- AXI_DATA_WIDTH, 8, width of tdata on every port.
- NUM_PORTS, 2, number of slave inputs; legal range 2..8.
- PORT_SEL_WIDTH, $clog2(NUM_PORTS), width of the grant index; not user-set.

Ports:
- aclk  in  1  single clock for all interfaces.
- aresetn  in  1  asynchronous assert, active-low reset; must be deasserted synchronously to aclk upstream.
- s_axis_tdata  in  NUM_PORTS*AXI_DATA_WIDTH  port p occupies bits [p*W +: W].
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port end of frame.
- s_axis_tuser  in  NUM_PORTS  per-port bad-frame flag; meaningful on the tlast beat only.
- s_axis_trdy  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  AXI_DATA_WIDTH  merged data.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tlast  out  1  merged end of frame.
- m_axis_tuser  out  1  merged bad-frame flag.
- m_axis_trdy  in  1  sink ready.
- o_grant  out  PORT_SEL_WIDTH  index of the currently or last granted port.
- o_busy  out  1  high while in state XFER.

Behaviour:
- Reset (async, while aresetn=0):
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0.
  - s_axis_trdy=0, o_grant=NUM_PORTS-1 (so port 0 wins first), o_busy=0, state=IDLE.
- FSM states: IDLE, XFER.
- IDLE:
  - s_axis_trdy all 0.
  - If any s_axis_tvalid is high: grant the first requester searching from o_grant+1 upward, wrapping modulo NUM_PORTS. Register o_grant and go to XFER.
  - Otherwise stay in IDLE.
  - Arbitration costs exactly one bubble cycle per frame.
- XFER:
  - Output register load enable: out_en = ~m_axis_tvalid | m_axis_trdy.
  - s_axis_trdy[o_grant] = out_en; all other bits of s_axis_trdy are 0 (combinational from m_axis_trdy and the register state).
  - A beat is accepted when s_axis_tvalid[g] & s_axis_trdy[g]. It is loaded into the output register the same edge, so latency is 1 cycle input-to-output.
  - On an accepted beat with tlast=1: return to IDLE. o_grant holds its value as the round-robin pointer.
  - If the granted port drops tvalid mid-frame, hold the grant indefinitely; there is no preemption and no timeout.
- Output register:
  - On an edge with out_en=1 and no accepted beat, m_axis_tvalid clears.
  - Data, tlast and tuser load only on an accepted beat.
  - Sustained throughput is 1 beat/cycle within a frame.
- Round robin:
  - With requesters {0,1} both continuously valid, frames alternate 0,1,0,1.
  - A sole requester receives back-to-back frames, with one bubble between them.
- Single-beat frame (tlast on the first beat): IDLE→XFER→IDLE, 2 cycles per frame.
- tuser is forwarded unchanged on every beat; the arbiter never drops or alters frames.
- Reset mid-frame:
  - Output clears immediately; the partial frame is abandoned.
  - The source must also be reset; the arbiter does not resynchronise frame boundaries.
- Requests arriving on the same edge that XFER→IDLE occurs are evaluated in the following IDLE cycle.

Decomposition:
- Shared package axi_stream_pkg:
  - arb_state_t enum {IDLE, XFER}.
  - Function next_rr_index(req, last) returning the grant index and a found flag.
- One sub-module rr_priority_select:
  - Purely combinational masked priority encoder.
  - Inputs: req[NUM_PORTS], last_grant.
  - Outputs: grant_idx, grant_valid.

Test Plan:
- Reset then idle: aresetn low for 3 cycles, all s_tvalid=0 → m_axis_tvalid=0, s_axis_trdy=0, o_grant=1 (NUM_PORTS=2), o_busy=0.
- Single port: port 1 sends a 4-beat frame 0xA0..0xA3, m_trdy=1 → first m beat 2 cycles after s_tvalid rises, 4 consecutive output beats, tlast on 0xA3, o_grant=1.
- Fairness: ports 0 and 1 each continuously send 3-beat frames (0x1x, 0x2x) → output frame order 0,1,0,1 with no beat interleaving; exactly one bubble between frames.
- Backpressure: m_trdy toggles 1,0,1,0 during port 0's 5-beat frame → no beat lost or duplicated; s_axis_trdy[0] tracks out_en; port 1 s_trdy remains 0.
- Stall and bad frame: granted port drops tvalid for 10 cycles mid-frame → grant held and port 1 ignored; the frame then ends with tuser=1 → m_axis_tuser=1 on the tlast beat.
- Async reset mid-frame: aresetn pulled low between clock edges during beat 2 → m_axis_tvalid=0 immediately without a clock edge; after release, arbitration restarts from port 0.

Source files
------------

// File: rtl/axi_stream_pkg.sv
// Shared arbitration types and the round-robin search helper used by the
// frame arbiter and its priority selector.
package axi_stream_pkg;

  localparam int MAX_PORTS = 8;
  localparam int MAX_SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_SEL_W-1:0] idx;
  } rr_result_t;

  // First requester strictly after 'last', wrapping modulo num_ports.
  function automatic rr_result_t next_rr_index(input logic [MAX_PORTS-1:0] req,
                                               input logic [MAX_SEL_W-1:0] last,
                                               input int num_ports);
    rr_result_t r;
    int         cand;
    r = '0;
    for (int i = 1; i <= MAX_PORTS; i++) begin
      cand = (int'(last) + i) % num_ports;
      if (i <= num_ports && !r.found && req[cand[MAX_SEL_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = MAX_SEL_W'(cand);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin priority encoder: picks the next requester after
// last_grant.
module rr_priority_select
  import axi_stream_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int SEL_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [SEL_W-1:0]     last_grant,
  output logic [SEL_W-1:0]     grant_idx,
  output logic                 grant_valid
);

  logic [MAX_PORTS-1:0] req_pad;
  logic [MAX_SEL_W-1:0] last_pad;
  rr_result_t           res;

  always_comb begin
    req_pad                  = '0;
    req_pad[NUM_PORTS-1:0]   = req;
    last_pad                 = '0;
    last_pad[SEL_W-1:0]      = last_grant;
    res                      = next_rr_index(req_pad, last_pad, NUM_PORTS);
  end

  assign grant_idx   = SEL_W'(res.idx);
  assign grant_valid = res.found;

endmodule

// File: rtl/axi_frame_arbiter.sv
// Frame-granular round-robin AXI-Stream merger with a registered output stage.
// Handshake: a beat moves on any edge where tvalid and trdy are both high.
module axi_frame_arbiter
  import axi_stream_pkg::*;
#(
  parameter  int AXI_DATA_WIDTH = 8,
  parameter  int NUM_PORTS      = 2,
  localparam int PORT_SEL_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [NUM_PORTS*AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                s_axis_tlast,
  input  logic [NUM_PORTS-1:0]                s_axis_tuser,
  output logic [NUM_PORTS-1:0]                s_axis_trdy,
  output logic [AXI_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  output logic                                m_axis_tuser,
  input  logic                                m_axis_trdy,
  output logic [PORT_SEL_WIDTH-1:0]           o_grant,
  output logic                                o_busy
);

  arb_state_t                state, state_nxt;
  logic [PORT_SEL_WIDTH-1:0] grant_idx;
  logic                      grant_valid;
  logic                      out_en, accept;
  logic                      sel_valid, sel_last, sel_user;
  logic [AXI_DATA_WIDTH-1:0] sel_data;

  rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .SEL_W     (PORT_SEL_WIDTH)
  ) u_sel (
    .req         (s_axis_tvalid),
    .last_grant  (o_grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    sel_data  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (o_grant == PORT_SEL_WIDTH'(p)) begin
        sel_valid = s_axis_tvalid[p];
        sel_last  = s_axis_tlast[p];
        sel_user  = s_axis_tuser[p];
        sel_data  = s_axis_tdata[p*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      end
    end
  end

  assign out_en = ~m_axis_tvalid | m_axis_trdy;
  assign accept = (state == XFER) & out_en & sel_valid;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = XFER;
      XFER:    if (accept && sel_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_axis_trdy = '0;
    if (state == XFER && out_en) s_axis_trdy[o_grant] = 1'b1;
    o_busy = (state == XFER);
  end

  // Reset value makes port 0 the first winner after reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                          o_grant <= PORT_SEL_WIDTH'(NUM_PORTS - 1);
    else if (state == IDLE && grant_valid) o_grant <= grant_idx;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (out_en) m_axis_tvalid <= accept;
      if (accept) begin
        m_axis_tdata <= sel_data;
        m_axis_tlast <= sel_last;
        m_axis_tuser <= sel_user;
      end
    end
  end

endmodule

// File: tb/tb_axi_frame_arbiter.sv
// Directed bench for the frame arbiter: cycle tables plus queue-driven sources
// for fairness, stall, bad-frame and asynchronous reset sequences.
module tb_axi_frame_arbiter;

  localparam int W  = 8;
  localparam int NP = 2;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [NP*W-1:0] s_axis_tdata;
  logic [NP-1:0]   s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_trdy;
  logic [W-1:0]    m_axis_tdata;
  logic            m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_trdy;
  logic            o_grant;
  logic            o_busy;

  always #5 aclk = ~aclk;

  axi_frame_arbiter #(.AXI_DATA_WIDTH(W), .NUM_PORTS(NP)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_trdy   (s_axis_trdy),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_trdy   (m_axis_trdy),
    .o_grant       (o_grant),
    .o_busy        (o_busy)
  );

  typedef struct {
    logic [1:0] v;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] l;
    logic       mt;
    logic [14:0] exp_out; // {m_tvalid, m_tdata, m_tlast, m_tuser, s_trdy, grant, busy}
  } vec_t;

  vec_t        vecs[$];
  logic [10:0] src_q[NP][$];   // {stall_after, user, last, data}
  logic [9:0]  exp_q[$];       // {user, last, data}
  int          checks, errors, cyc, beat_cnt, prev_cyc;
  int          stall_cnt[NP];
  logic [NP-1:0] acc, in_stall;
  logic        direct, gap_chk, prev_v, prev_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic addv(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [1:0] l, input logic mt, input logic ev, input logic [7:0] ed,
                      input logic el, input logic [1:0] es, input logic eg, input logic eb);
    vec_t r;
    r.v = v; r.d0 = d0; r.d1 = d1; r.l = l; r.mt = mt;
    r.exp_out = {ev, ed, el, 1'b0, es, eg, eb};
    vecs.push_back(r);
  endtask

  function automatic logic [10:0] ent(input logic st, input logic u, input logic l, input logic [7:0] d);
    return {st, u, l, d};
  endfunction

  task automatic clear_src();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      stall_cnt[p] = 0;
    end
    exp_q.delete();
    acc = '0; in_stall = '0;
    s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tuser = '0; s_axis_tdata = '0;
  endtask

  task automatic drive_src();
    logic [10:0] e;
    for (int p = 0; p < NP; p++) begin
      if (acc[p] && src_q[p].size() > 0) begin
        e = src_q[p].pop_front();
        if (e[10]) stall_cnt[p] = 10;
      end
      in_stall[p] = (stall_cnt[p] > 0);
      if (in_stall[p]) stall_cnt[p]--;
      if (src_q[p].size() > 0 && !in_stall[p]) begin
        e = src_q[p][0];
        s_axis_tvalid[p]       = 1'b1;
        s_axis_tuser[p]        = e[9];
        s_axis_tlast[p]        = e[8];
        s_axis_tdata[p*W +: W] = e[7:0];
      end else begin
        s_axis_tvalid[p]       = 1'b0;
        s_axis_tuser[p]        = 1'b0;
        s_axis_tlast[p]        = 1'b0;
        s_axis_tdata[p*W +: W] = '0;
      end
    end
  endtask

  task automatic monitor();
    logic [9:0] e;
    if (m_axis_tvalid && m_axis_trdy) begin
      beat_cnt++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got 0x%0h expected none (cycle %0d)",
                 {m_axis_tuser, m_axis_tlast, m_axis_tdata}, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {22'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, {22'd0, e});
      end
      if (gap_chk && prev_v) chk("frame_gap", cyc - prev_cyc, prev_last ? 2 : 1);
      prev_v = 1'b1; prev_cyc = cyc; prev_last = m_axis_tlast;
    end
    if (in_stall[0]) begin
      chk("stall_grant", {31'd0, o_grant}, 32'd0);
      chk("stall_trdy1", {31'd0, s_axis_trdy[1]}, 32'd0);
      chk("stall_busy", {31'd0, o_busy}, 32'd1);
    end
  endtask

  task automatic cycle();
    @(posedge aclk); #1;
    if (!direct) drive_src();
    @(negedge aclk);
    cyc++;
    acc = s_axis_tvalid & s_axis_trdy;
    if (!direct) monitor();
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      cycle();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (3) cycle();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_src();
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; beat_cnt = 0; prev_cyc = 0;
    direct = 1'b1; gap_chk = 1'b0; prev_v = 1'b0; prev_last = 1'b0;
    m_axis_trdy = 1'b1;
    aresetn = 1'b0;
    clear_src();

    // Reset state
    repeat (3) @(negedge aclk);
    chk("rst_mvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_mlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("rst_muser", {31'd0, m_axis_tuser}, 32'd0);
    chk("rst_mdata", {24'd0, m_axis_tdata}, 32'd0);
    chk("rst_strdy", {30'd0, s_axis_trdy}, 32'd0);
    chk("rst_grant", {31'd0, o_grant}, 32'd1);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    @(posedge aclk); #1 aresetn = 1'b1;

    // Port 1 four-beat frame, sink always ready
    addv(2'b10, 8'h00, 8'hA0, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0);
    addv(2'b10, 8'h00, 8'hA0, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 2'b10, 1'b1, 1'b1);
    addv(2'b10, 8'h00, 8'hA1, 2'b00, 1'b1, 1'b1, 8'hA0, 1'b0, 2'b10, 1'b1, 1'b1);
    addv(2'b10, 8'h00, 8'hA2, 2'b00, 1'b1, 1'b1, 8'hA1, 1'b0, 2'b10, 1'b1, 1'b1);
    addv(2'b10, 8'h00, 8'hA3, 2'b10, 1'b1, 1'b1, 8'hA2, 1'b0, 2'b10, 1'b1, 1'b1);
    addv(2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1, 8'hA3, 1'b1, 2'b00, 1'b1, 1'b0);
    addv(2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 8'hA3, 1'b1, 2'b00, 1'b1, 1'b0);
    // Port 0 five-beat frame with sink ready toggling
    addv(2'b01, 8'hB0, 8'h00, 2'b00, 1'b1, 1'b0, 8'hA3, 1'b1, 2'b00, 1'b1, 1'b0);
    addv(2'b01, 8'hB0, 8'h00, 2'b00, 1'b1, 1'b0, 8'hA3, 1'b1, 2'b01, 1'b0, 1'b1);
    addv(2'b01, 8'hB1, 8'h00, 2'b00, 1'b0, 1'b1, 8'hB0, 1'b0, 2'b00, 1'b0, 1'b1);
    addv(2'b01, 8'hB1, 8'h00, 2'b00, 1'b1, 1'b1, 8'hB0, 1'b0, 2'b01, 1'b0, 1'b1);
    addv(2'b01, 8'hB2, 8'h00, 2'b00, 1'b0, 1'b1, 8'hB1, 1'b0, 2'b00, 1'b0, 1'b1);
    addv(2'b01, 8'hB2, 8'h00, 2'b00, 1'b1, 1'b1, 8'hB1, 1'b0, 2'b01, 1'b0, 1'b1);
    addv(2'b01, 8'hB3, 8'h00, 2'b00, 1'b0, 1'b1, 8'hB2, 1'b0, 2'b00, 1'b0, 1'b1);
    addv(2'b01, 8'hB3, 8'h00, 2'b00, 1'b1, 1'b1, 8'hB2, 1'b0, 2'b01, 1'b0, 1'b1);
    addv(2'b01, 8'hB4, 8'h00, 2'b01, 1'b0, 1'b1, 8'hB3, 1'b0, 2'b00, 1'b0, 1'b1);
    addv(2'b01, 8'hB4, 8'h00, 2'b01, 1'b1, 1'b1, 8'hB3, 1'b0, 2'b01, 1'b0, 1'b1);
    addv(2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 8'hB4, 1'b1, 2'b00, 1'b0, 1'b0);
    addv(2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1, 8'hB4, 1'b1, 2'b00, 1'b0, 1'b0);
    addv(2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 8'hB4, 1'b1, 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge aclk); #1;
      s_axis_tvalid = vecs[i].v;
      s_axis_tdata  = {vecs[i].d1, vecs[i].d0};
      s_axis_tlast  = vecs[i].l;
      s_axis_tuser  = 2'b00;
      m_axis_trdy   = vecs[i].mt;
      @(negedge aclk);
      cyc++;
      chk($sformatf("vec%0d", i),
          {17'd0, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, s_axis_trdy, o_grant, o_busy},
          {17'd0, vecs[i].exp_out});
    end

    // Fairness: both ports continuously offer 3-beat frames
    m_axis_trdy = 1'b1;
    do_reset();
    direct = 1'b0;
    gap_chk = 1'b1; prev_v = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 3; b++) begin
        src_q[0].push_back(ent(1'b0, 1'b0, b == 2, 8'h10 + 8'(f*3 + b)));
        src_q[1].push_back(ent(1'b0, 1'b0, b == 2, 8'h20 + 8'(f*3 + b)));
      end
    end
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 3; b++) exp_q.push_back({1'b0, b == 2, 8'h10 + 8'(f*3 + b)});
      for (int b = 0; b < 3; b++) exp_q.push_back({1'b0, b == 2, 8'h20 + 8'(f*3 + b)});
    end
    drain(200);
    gap_chk = 1'b0;
    chk("fair_grant", {31'd0, o_grant}, 32'd1);

    // Stall mid-frame on port 0, then a bad frame end
    src_q[0].push_back(ent(1'b0, 1'b0, 1'b0, 8'h30));
    src_q[0].push_back(ent(1'b1, 1'b0, 1'b0, 8'h31));
    src_q[0].push_back(ent(1'b0, 1'b0, 1'b0, 8'h32));
    src_q[0].push_back(ent(1'b0, 1'b1, 1'b1, 8'h33));
    src_q[1].push_back(ent(1'b0, 1'b0, 1'b0, 8'h40));
    src_q[1].push_back(ent(1'b0, 1'b0, 1'b1, 8'h41));
    exp_q.push_back({1'b0, 1'b0, 8'h30});
    exp_q.push_back({1'b0, 1'b0, 8'h31});
    exp_q.push_back({1'b0, 1'b0, 8'h32});
    exp_q.push_back({1'b1, 1'b1, 8'h33});
    exp_q.push_back({1'b0, 1'b0, 8'h40});
    exp_q.push_back({1'b0, 1'b1, 8'h41});
    drain(200);

    // Asynchronous reset during beat 2 of a port 0 frame
    for (int b = 0; b < 4; b++) src_q[0].push_back(ent(1'b0, 1'b0, b == 3, 8'h50 + 8'(b)));
    for (int b = 0; b < 4; b++) exp_q.push_back({1'b0, b == 3, 8'h50 + 8'(b)});
    beat_cnt = 0;
    for (int n = 0; n < 50 && beat_cnt < 2; n++) cycle();
    chk("rst_mid_beats", beat_cnt, 2);
    #2 aresetn = 1'b0;
    #1;
    chk("async_mvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("async_mdata", {24'd0, m_axis_tdata}, 32'd0);
    chk("async_strdy", {30'd0, s_axis_trdy}, 32'd0);
    chk("async_busy", {31'd0, o_busy}, 32'd0);
    chk("async_grant", {31'd0, o_grant}, 32'd1);
    clear_src();
    repeat (3) cycle();
    @(posedge aclk); #1 aresetn = 1'b1;
    src_q[0].push_back(ent(1'b0, 1'b0, 1'b1, 8'h60));
    src_q[1].push_back(ent(1'b0, 1'b0, 1'b1, 8'h70));
    exp_q.push_back({1'b0, 1'b1, 8'h60});
    exp_q.push_back({1'b0, 1'b1, 8'h70});
    drain(100);
    chk("final_grant", {31'd0, o_grant}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
